data_ram_responder: RTL and testbench
=====================================

# data_ram_responder

Memory-side responder for the processor's 256-bit vector/scalar RAM port, the slave end of the `address_RAM` / `byteena_RAM` / `writeData_RAM` / `rden_RAM` / `wren_RAM` / `readData_RAM` interface driven by the load/store unit. It holds a word-addressed array of 256-bit lines with 32 byte-lane write enables and returns read data through a fixed-latency pipeline with a valid strobe. After reset it runs a clearing sweep that zeroes the whole array before it accepts traffic.

## Interface
- `AW`, 10: implemented index bits; depth = 2^AW lines; `address_RAM[13:AW]` ignored (aliasing).
- `READ_LATENCY`, 2: cycles from request to data, legal 1..4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `address_RAM`  in  14  line address.
- `byteena_RAM`  in  32  write byte enables; bit i gates bits [8i+7:8i].
- `writeData_RAM`  in  256  write data.
- `rden_RAM`  in  1  read request.
- `wren_RAM`  in  1  write request.
- `readData_RAM`  out  256  read data, held between reads.
- `rvalid_RAM`  out  1  one-cycle strobe per completed read.
- `ready_RAM`  out  1  high when requests are accepted (clear sweep done).
- `drop_err`  out  1  sticky: a request arrived while `ready_RAM` low.

## Operation
- States: CLEAR, READY. Reset (reset=0) forces CLEAR, `clear_ptr`=0, all outputs 0, read pipeline flushed.
- CLEAR: each rising edge with reset=1 writes 256'h0 to line `clear_ptr`, increments it; the edge that writes line 2^AW-1 moves to READY. `ready_RAM`=1 in READY only.
- In CLEAR, `rden_RAM`/`wren_RAM` are ignored (no array change, no rvalid) and set `drop_err`; cleared only by reset.
- Write (READY, `wren_RAM`=1): at the edge, lanes with `byteena_RAM[i]`=1 take `writeData_RAM` bytes; other lanes unchanged. `byteena_RAM`=0 is a legal no-op write.
- Read (READY, `rden_RAM`=1): full line at index sampled at the edge enters stage 1; `byteena_RAM` has no effect on reads. Writes on earlier edges are always visible.
- Simultaneous read+write, any address: write always performed. Same-address data returned per Configuration.
- Pipeline is a READ_LATENCY-deep valid/data shift register; one read accepted per cycle, back-to-back reads stream at full rate, order preserved.
- Last stage loads `readData_RAM` only when its valid bit is set; otherwise `readData_RAM` holds.
- Reset asserted mid-operation: in-flight reads discarded (no rvalid), array contents undefined until the new sweep clears them.

## Timing
- Request sampled at edge ending cycle n -> `rvalid_RAM`=1 and `readData_RAM` valid during cycle n+READ_LATENCY.
- Clear sweep: `ready_RAM` rises in the cycle after the 2^AW-th edge following reset release.
- All outputs registered; no combinational path inputs -> outputs.

## Configuration
- `RAM_RDW_BYPASS_EN` defined: same-cycle read+write to the same index returns the merged line (new bytes in enabled lanes, old bytes elsewhere).
- Undefined: same-cycle read+write to the same index returns the old line (read-before-write). Different indices unaffected either way.

## Test plan
- AW=4, L=2: release reset -> `ready_RAM`=0 for 16 edges, then 1; read every line -> all 256'h0, one `rvalid_RAM` each, 2 cycles after request.
- Write line 3 all-ones with byteena=32'h0000_000F, then read 3 -> readData = {224'h0, 32'hFFFF_FFFF}; read line 19 (alias) -> same value.
- Back-to-back reads lines 1,2,3 after writing 0x11/0x22/0x33 per byte -> three consecutive rvalid cycles, data in order; readData holds 0x33.. after.
- Same-cycle rden+wren line 5 (old 0, new 0xAA.., byteena all ones) -> 0 without macro, 0xAA.. with `RAM_RDW_BYPASS_EN`.
- wren during CLEAR -> `drop_err`=1, line stays 0 after sweep; `drop_err` cleared only by reset.
- Reset pulsed with read in flight -> no rvalid, outputs 0, new 16-cycle sweep, `ready_RAM` low throughout.

Source files
------------

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - 256-bit byte-lane RAM responder with clear sweep and fixed-latency read pipeline
// Optional feature macro: RAM_RDW_BYPASS_EN (same-index read+write returns merged line)
module data_ram_responder #(
    parameter int AW           = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [13:0]  address_RAM,
    input  logic [31:0]  byteena_RAM,
    input  logic [255:0] writeData_RAM,
    input  logic         rden_RAM,
    input  logic         wren_RAM,
    output logic [255:0] readData_RAM,
    output logic         rvalid_RAM,
    output logic         ready_RAM,
    output logic         drop_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [AW-1:0]  r_clear_ptr;
    logic           r_ready;
    logic           r_drop_err;
    logic [255:0]   r_mem [0:(1<<AW)-1];

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [255:0]            r_pipe_data [0:READ_LATENCY-1];

    logic [AW-1:0]  w_idx;
    logic           w_rd_acc;
    logic           w_wr_acc;
    logic           w_sweep_last;
    logic [255:0]   w_old_line;
    logic [255:0]   w_merged_line;
    logic [255:0]   w_rd_line;
    logic           w_addr_unused;

    // Upper address bits alias onto the implemented depth.
    assign w_idx         = address_RAM[AW-1:0];
    assign w_addr_unused = ^address_RAM[13:AW];

    // Requests only take effect once the sweep has finished.
    assign w_rd_acc     = (r_state == ST_READY) && rden_RAM;
    assign w_wr_acc     = (r_state == ST_READY) && wren_RAM;
    assign w_sweep_last = (r_clear_ptr == {AW{1'b1}});

    assign w_old_line = r_mem[w_idx];

    // Overlay the enabled write lanes onto the currently stored line.
    always_comb begin
        w_merged_line = w_old_line;
        for (int i = 0; i < 32; i++) begin
            if (byteena_RAM[i]) begin
                w_merged_line[8*i +: 8] = writeData_RAM[8*i +: 8];
            end
        end
    end

`ifdef RAM_RDW_BYPASS_EN
    // Same-cycle write to the read index is forwarded into the read data.
    assign w_rd_line = w_wr_acc ? w_merged_line : w_old_line;
`else
    // Read-before-write: the array value before this edge's write is returned.
    assign w_rd_line = w_old_line;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave CLEAR on the edge that zeroes the last line.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_sweep_last) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Sweep pointer, registered ready flag and sticky drop error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clear_ptr <= '0;
            r_ready     <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clear_ptr <= r_clear_ptr + 1'b1;
            end
            r_ready <= (w_state_nxt == ST_READY);
            if ((r_state == ST_CLEAR) && (rden_RAM || wren_RAM)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Array storage: sweep zeroes one line per edge, then byte-lane writes.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clear_ptr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_idx] <= w_merged_line;
        end
    end

    // Read pipeline: valid shifts every edge, data stages load only behind a valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_pipe_data[0] <= w_rd_line;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) begin
                    r_pipe_data[i] <= r_pipe_data[i-1];
                end
            end
        end
    end

    assign readData_RAM = r_pipe_data[READ_LATENCY-1];
    assign rvalid_RAM   = r_pipe_vld[READ_LATENCY-1];
    assign ready_RAM    = r_ready;
    assign drop_err     = r_drop_err;

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - directed self-checking bench for data_ram_responder (AW=4, latency 2)
module tb_data_ram_responder;

    logic         clk;
    logic         reset;
    logic [13:0]  address_RAM;
    logic [31:0]  byteena_RAM;
    logic [255:0] writeData_RAM;
    logic         rden_RAM;
    logic         wren_RAM;
    logic [255:0] readData_RAM;
    logic         rvalid_RAM;
    logic         ready_RAM;
    logic         drop_err;

    int n_asserts;
    int n_fail;

    logic [255:0] exp_line;
    logic [255:0] ones_line;

    data_ram_responder #(.AW(4), .READ_LATENCY(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .address_RAM  (address_RAM),
        .byteena_RAM  (byteena_RAM),
        .writeData_RAM(writeData_RAM),
        .rden_RAM     (rden_RAM),
        .wren_RAM     (wren_RAM),
        .readData_RAM (readData_RAM),
        .rvalid_RAM   (rvalid_RAM),
        .ready_RAM    (ready_RAM),
        .drop_err     (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rden_RAM      = 1'b0;
        wren_RAM      = 1'b0;
        byteena_RAM   = '0;
        writeData_RAM = '0;
        address_RAM   = '0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [255:0] d, input logic [31:0] be);
        address_RAM   = a;
        writeData_RAM = d;
        byteena_RAM   = be;
        wren_RAM      = 1'b1;
        step();
        idle_inputs();
    endtask

    // Single read, checking the strobe is absent one cycle after request and present at two.
    task automatic do_read(input string tag, input logic [13:0] a, input logic [255:0] exp);
        address_RAM = a;
        rden_RAM    = 1'b1;
        step();
        idle_inputs();
        chk({tag, "_rvalid_early"}, {255'h0, rvalid_RAM}, 256'h0);
        step();
        chk({tag, "_rvalid"}, {255'h0, rvalid_RAM}, 256'h1);
        chk({tag, "_data"}, readData_RAM, exp);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        ones_line = '1;
        reset     = 1'b0;
        idle_inputs();

        // Reset state
        step();
        chk("rst_ready", {255'h0, ready_RAM}, 256'h0);
        chk("rst_rvalid", {255'h0, rvalid_RAM}, 256'h0);
        chk("rst_rdata", readData_RAM, 256'h0);
        chk("rst_drop", {255'h0, drop_err}, 256'h0);

        // Release reset; write attempt during the sweep must be dropped
        reset         = 1'b1;
        address_RAM   = 14'd7;
        writeData_RAM = ones_line;
        byteena_RAM   = 32'hFFFF_FFFF;
        wren_RAM      = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            idle_inputs();
            chk($sformatf("sweep_ready_%0d", k), {255'h0, ready_RAM}, (k == 16) ? 256'h1 : 256'h0);
            if (k == 1) chk("drop_set", {255'h0, drop_err}, 256'h1);
        end

        // Stream reads of all 16 lines; expect zeros and one strobe each
        for (int c = 0; c < 18; c++) begin
            rden_RAM    = (c < 16);
            address_RAM = 14'(c);
            step();
            chk($sformatf("sweep_rv_%0d", c), {255'h0, rvalid_RAM},
                (c >= 1 && c <= 16) ? 256'h1 : 256'h0);
            if (c >= 1 && c <= 16) chk($sformatf("sweep_rd_%0d", c - 1), readData_RAM, 256'h0);
        end
        idle_inputs();

        // Partial-lane write, then read through alias
        do_write(14'd3, ones_line, 32'h0000_000F);
        exp_line = {224'h0, 32'hFFFF_FFFF};
        do_read("rd3", 14'd3, exp_line);
        step();
        chk("rd3_rvalid_late", {255'h0, rvalid_RAM}, 256'h0);
        chk("rd3_hold", readData_RAM, exp_line);
        do_read("rd19", 14'd19, exp_line);

        // Zero byte-enable write is a no-op
        do_write(14'd3, 256'h0, 32'h0);
        do_read("rd3_noop", 14'd3, exp_line);

        // Back-to-back reads of 1,2,3
        do_write(14'd1, {32{8'h11}}, 32'hFFFF_FFFF);
        do_write(14'd2, {32{8'h22}}, 32'hFFFF_FFFF);
        do_write(14'd3, {32{8'h33}}, 32'hFFFF_FFFF);
        rden_RAM    = 1'b1;
        address_RAM = 14'd1;
        step();
        chk("b2b_rv0", {255'h0, rvalid_RAM}, 256'h0);
        address_RAM = 14'd2;
        step();
        chk("b2b_rv1", {255'h0, rvalid_RAM}, 256'h1);
        chk("b2b_d1", readData_RAM, {32{8'h11}});
        address_RAM = 14'd3;
        step();
        idle_inputs();
        chk("b2b_rv2", {255'h0, rvalid_RAM}, 256'h1);
        chk("b2b_d2", readData_RAM, {32{8'h22}});
        step();
        chk("b2b_rv3", {255'h0, rvalid_RAM}, 256'h1);
        chk("b2b_d3", readData_RAM, {32{8'h33}});
        step();
        chk("b2b_rv_end", {255'h0, rvalid_RAM}, 256'h0);
        chk("b2b_hold", readData_RAM, {32{8'h33}});

        // Same-cycle read+write to line 5
        address_RAM   = 14'd5;
        writeData_RAM = {32{8'hAA}};
        byteena_RAM   = 32'hFFFF_FFFF;
        wren_RAM      = 1'b1;
        rden_RAM      = 1'b1;
        step();
        idle_inputs();
        step();
`ifdef RAM_RDW_BYPASS_EN
        exp_line = {32{8'hAA}};
`else
        exp_line = 256'h0;
`endif
        chk("rdw_rvalid", {255'h0, rvalid_RAM}, 256'h1);
        chk("rdw_data", readData_RAM, exp_line);
        do_read("rd5_after", 14'd5, {32{8'hAA}});

        // Dropped sweep write left line 7 zero; drop_err still sticky
        do_read("rd7", 14'd7, 256'h0);
        chk("drop_sticky", {255'h0, drop_err}, 256'h1);

        // Reset with a read in flight
        address_RAM = 14'd5;
        rden_RAM    = 1'b1;
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid", {255'h0, rvalid_RAM}, 256'h0);
        chk("mid_rst_rdata", readData_RAM, 256'h0);
        chk("mid_rst_ready", {255'h0, ready_RAM}, 256'h0);
        chk("mid_rst_drop", {255'h0, drop_err}, 256'h0);
        step();
        chk("rst_hold_rvalid", {255'h0, rvalid_RAM}, 256'h0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("sweep2_ready_%0d", k), {255'h0, ready_RAM}, (k == 16) ? 256'h1 : 256'h0);
            chk($sformatf("sweep2_rv_%0d", k), {255'h0, rvalid_RAM}, 256'h0);
        end
        do_read("rd5_swept", 14'd5, 256'h0);
        do_read("rd3_swept", 14'd3, 256'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
